// File: rtl/l15_msg1_arb_pkg.sv
// Shared widths, message codes and arbiter state encodings for the
// L1.5 -> L2 msg1 request arbiter.
package l15_msg1_arb_pkg;

    localparam int MSG_WIDTH  = 8;
    localparam int DATA_WIDTH = 64;
    localparam int TAG_WIDTH  = 8;
    localparam int OWNER_BITS = 2;
    localparam int NUM_CORES  = 4;
    localparam int CNT_WIDTH  = 16;

    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY = 8'd0;

    typedef enum logic {
        ARB_ST_ARB  = 1'b0,
        ARB_ST_HOLD = 1'b1
    } arb_st_e;

endpackage

// File: rtl/l15_msg1_arb_rr_pick4.sv
// Combinational 4-way rotating priority picker: first set request
// searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt,
    output logic       any
);

    logic [1:0] idx;

    // Walk from farthest to nearest offset so the nearest hit wins.
    always_comb begin
        gnt = 2'd0;
        any = 1'b0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l15_msg1_arb.sv
// Round-robin arbiter sharing the L1.5 -> L2 msg1 channel among four cores.
// Optional per-core grant counters are enabled with CCP_ARB_STATS_EN.
module l15_msg1_arb
    import l15_msg1_arb_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            req_valid,
    output logic [NUM_CORES-1:0]            req_ready,
    input  logic [NUM_CORES*MSG_WIDTH-1:0]  req_type,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_CORES*TAG_WIDTH-1:0]  req_tag,
    output logic                            msg1_valid,
    input  logic                            msg1_ready,
    output logic [MSG_WIDTH-1:0]            msg1_type,
    output logic [DATA_WIDTH-1:0]           msg1_data,
    output logic [TAG_WIDTH-1:0]            msg1_tag,
    output logic [OWNER_BITS-1:0]           msg1_source
`ifdef CCP_ARB_STATS_EN
   ,output logic [NUM_CORES*CNT_WIDTH-1:0]  grant_cnt
`endif
);

    logic [NUM_CORES-1:0]                 buf_v;
    logic [NUM_CORES-1:0][MSG_WIDTH-1:0]  buf_type;
    logic [NUM_CORES-1:0][DATA_WIDTH-1:0] buf_data;
    logic [NUM_CORES-1:0][TAG_WIDTH-1:0]  buf_tag;

    arb_st_e         state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      hold_q, hold_d;
    logic [1:0]      pick;
    logic            any;
    logic [1:0]      gnt;
    logic            drain;
    logic [NUM_CORES-1:0] drain_vec;
    logic [NUM_CORES-1:0] load;

    rr_pick4 u_pick (
        .req (buf_v),
        .ptr (ptr_q),
        .gnt (pick),
        .any (any)
    );

    assign gnt        = (state_q == ARB_ST_HOLD) ? hold_q : pick;
    assign msg1_valid = (state_q == ARB_ST_HOLD) || any;
    assign drain      = msg1_valid && msg1_ready;

    always_comb begin
        drain_vec = '0;
        load      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            drain_vec[i] = drain && (gnt == 2'(i));
            load[i]      = req_valid[i] && req_ready[i] &&
                           (req_type[i*MSG_WIDTH +: MSG_WIDTH] != MSG_TYPE_EMPTY);
        end
    end

    assign req_ready = ~buf_v | drain_vec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_v <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (load[i])
                    buf_v[i] <= 1'b1;
                else if (drain_vec[i])
                    buf_v[i] <= 1'b0;
            end
        end
    end

    // Payload needs no reset; it is only observed behind buf_v.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (load[i]) begin
                buf_type[i] <= req_type[i*MSG_WIDTH +: MSG_WIDTH];
                buf_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
                buf_tag[i]  <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_ST_ARB;
            ptr_q   <= 2'd0;
            hold_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            ARB_ST_ARB: begin
                if (any) begin
                    if (msg1_ready) begin
                        ptr_d = pick + 2'd1;
                    end else begin
                        state_d = ARB_ST_HOLD;
                        hold_d  = pick;
                    end
                end
            end
            ARB_ST_HOLD: begin
                if (msg1_ready) begin
                    ptr_d   = hold_q + 2'd1;
                    state_d = ARB_ST_ARB;
                end
            end
        endcase
    end

    always_comb begin
        msg1_type   = MSG_TYPE_EMPTY;
        msg1_data   = '0;
        msg1_tag    = '0;
        msg1_source = '0;
        if (msg1_valid) begin
            msg1_type   = buf_type[gnt];
            msg1_data   = buf_data[gnt];
            msg1_tag    = buf_tag[gnt];
            msg1_source = gnt;
        end
    end

`ifdef CCP_ARB_STATS_EN
    logic [NUM_CORES-1:0][CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (drain_vec[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}}))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/l15_msg1_arb.md
# l15_msg1_arb

Round-robin arbiter that shares the single L1.5→L2 msg1 request channel among the four L1.5 cache instances of the CMP. Each core owns a one-entry holding buffer; the arbiter picks one buffered request per handshake, drives it onto msg1 with the source core index, and keeps the grant locked until L2 accepts it. It sits between the per-core `l15` msg1 outputs and the L2 msg1 input, replacing the combinational pointer mux.

## Interface
- Parameters: none. All widths (`MSG_WIDTH`, `DATA_WIDTH`, `TAG_WIDTH`, `OWNER_BITS`=2) and `MSG_TYPE_EMPTY` come from `ccp_define.h`.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  one clock; reset is synchronous and active-low (state clears on a posedge where rst==0).
- req_valid  in  4  per-core request valid.
- req_ready  out  4  per-core buffer can accept.
- req_type  in  4*MSG_WIDTH  core i at slice i.
- req_data  in  4*DATA_WIDTH  core i at slice i.
- req_tag  in  4*TAG_WIDTH  core i at slice i.
- msg1_valid  out  1  request presented to L2.
- msg1_ready  in  1  L2 accepts this cycle.
- msg1_type / msg1_data / msg1_tag  out  MSG/DATA/TAG_WIDTH  granted payload.
- msg1_source  out  OWNER_BITS  granted core index.
- grant_cnt  out  4*16  per-core accepted-grant counters (only with `CCP_ARB_STATS_EN`).

## Operation
- Per core i: buffer buf_v[i] plus payload. Load when req_valid[i] && req_ready[i]. req_valid with type == `MSG_TYPE_EMPTY` is ignored (not loaded).
- req_ready[i] = !buf_v[i] || (drain of core i this cycle). A same-cycle drain and refill keeps buf_v[i]=1 with the new payload.
- Drain: msg1_valid && msg1_ready clears buf_v[gnt] (unless refilled).
- FSM, 2 states:
  - ARB: gnt = first i with buf_v[i], searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). msg1_valid = |buf_v. If valid && !msg1_ready → HOLD with gnt latched. If valid && msg1_ready → ptr <= gnt+1 (2-bit wrap), remain in ARB.
  - HOLD: gnt fixed to the latched index, msg1_valid=1, payload stable. On msg1_ready → ptr <= gnt+1, → ARB. New requests from other cores never preempt.
- When msg1_valid=0: msg1_type = `MSG_TYPE_EMPTY`, data/tag/source = 0.
- Payload is driven straight from buf[gnt]; no output register.

## Timing
- Reset: buf_v=0, ptr=0, state=ARB, msg1_valid=0, msg1_type=`MSG_TYPE_EMPTY`, msg1_data/tag/source=0, req_ready=4'hF, grant_cnt=0.
- Latency: a request accepted at edge E appears on msg1 in the cycle after E if it wins arbitration.
- Per-core throughput is 1 request/cycle with back-to-back drain and refill. Aggregate throughput is 1/cycle while msg1_ready=1.
- Fairness: a pending core waits at most 3 grants.
- Combinational path msg1_ready → req_ready is intentional.
- Reset mid-HOLD: the pending request is dropped and msg1_valid=0 in the next cycle.

## Configuration
- `CCP_ARB_STATS_EN` defined: grant_cnt[i] increments on each drain of core i and saturates at 16'hFFFF.
- Undefined: the grant_cnt port and the counters are absent. Arbitration is identical either way.

## Structure
- Add the following to `ccp_define.h`: `ARB_ST_ARB`/`ARB_ST_HOLD` encodings and `NUM_CORES`=4. The message type codes are already there.
- One sub-module, `rr_pick4`: combinational 4-way priority picker (inputs: req vector, ptr; outputs: gnt index, any). The top instantiates it once.

## Test plan
- Reset then idle → msg1_valid=0, msg1_type=EMPTY, req_ready=4'hF, source=0.
- Cores 0–3 load simultaneously at ptr=0, msg1_ready=1 continuously → sources 0,1,2,3 on consecutive cycles, then msg1_valid=0.
- Core 2 loads tag=5, data=0xAB, with msg1_ready=0 for 3 cycles; core 0 loads during the stall → source=2, tag=5, data=0xAB held stable all 3 cycles; core 0 is granted next.
- Core 1 issues back-to-back requests with same-cycle refill while msg1_ready=1 → one grant per cycle, no bubble, req_ready[1] stays 1.
- rst=0 asserted during HOLD with core 3 pending → next cycle msg1_valid=0, buf_v=0, ptr=0.
- With `CCP_ARB_STATS_EN`: 5 grants to core 0 and 2 to core 3 → grant_cnt slices read 5,0,0,2. Forcing a counter to 16'hFFFF and granting again leaves it at 16'hFFFF.
